// File: rtl/centipede_io_pkg.sv
// rtl/centipede_io_pkg.sv - Centipede I/O responder decode constants and latch bit map
package centipede_io_pkg;

  // Address region selectors (cpu_addr[13:10])
  localparam logic [3:0] ADR_DSW    = 4'b0010;
  localparam logic [3:0] ADR_IN     = 4'b0011;
  localparam logic [3:0] ADR_IRQACK = 4'b0110;
  localparam logic [3:0] ADR_OUTLAT = 4'b0111;
  localparam logic [3:0] ADR_WDOG   = 4'b1000;

  // Addressable output latch bit indices
  localparam int COIN_L = 0;
  localparam int COIN_C = 1;
  localparam int COIN_R = 2;
  localparam int LED1   = 3;
  localparam int LED2   = 4;
  localparam int FLIP   = 7;

  function automatic logic [3:0] adr_region(input logic [15:0] addr);
    return addr[13:10];
  endfunction

endpackage

// File: rtl/centipede_watchdog.sv
// rtl/centipede_watchdog.sv - Vblank-counting watchdog, kicked by CPU writes; wdog_reset is sticky
module centipede_watchdog #(
  parameter int WDOG_LIMIT = 8,
  parameter int WDOG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kick,
  input  logic              vblank_rise,
  output logic [WDOG_W-1:0] count,
  output logic              wdog_reset
);

  localparam logic [WDOG_W-1:0] LIMIT_C = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] count_q, count_d;
  logic              wdog_q, wdog_d;

  // Kick beats a coincident vblank edge; count saturates at the limit
  always_comb begin
    count_d = count_q;
    if (kick) begin
      count_d = '0;
    end else if (vblank_rise && (count_q != LIMIT_C)) begin
      count_d = count_q + 1'b1;
    end
    wdog_d = wdog_q | (count_q == LIMIT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wdog_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wdog_q  <= wdog_d;
    end
  end

  assign count      = count_q;
  assign wdog_reset = wdog_q;

endmodule

// File: rtl/centipede_io_responder.sv
// rtl/centipede_io_responder.sv - Centipede bus responder: read mux, IRQ latch, output latch, watchdog
// Optional watchdog enabled by defining CENTIPEDE_WATCHDOG_EN.
import centipede_io_pkg::*;

module centipede_io_responder #(
  parameter int WDOG_LIMIT = 8,
  parameter int WDOG_W     = 4,
  parameter int IRQ_VBIT   = 5
) (
  input  logic        clk_cpu_4x,
  input  logic        reset_cpu_n,
  input  logic        clk_cpu,
  input  logic        clk_cpu_2x,
  input  logic        cpu_read,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  ext_rd_data,
  input  logic [7:0]  sw_dsw1,
  input  logic [7:0]  sw_dsw2,
  input  logic [7:0]  sw_in0,
  input  logic [7:0]  sw_in1,
  input  logic [7:0]  sw_in2,
  input  logic [7:0]  sw_in3,
  input  logic [7:0]  vcount,
  input  logic        vblank,
  output logic        cpu_irq,
  output logic [7:0]  out_latch,
  output logic        wdog_reset
);

  logic [3:0] region;
  logic       wr_stb;
  logic       irq_ack;
  logic       wdog_kick;
  logic [7:0] rd_data_d, rd_data_q;
  logic [7:0] out_latch_d, out_latch_q;
  logic       irq_d, irq_q;
  logic       vbit_q;
  logic       irq_rise;

  assign region    = adr_region(cpu_addr);
  // One 4x edge per CPU cycle: the 2x-high, 1x-low phase
  assign wr_stb    = !cpu_read && clk_cpu_2x && !clk_cpu;
  assign irq_ack   = wr_stb && (region == ADR_IRQACK);
  assign wdog_kick = wr_stb && (region == ADR_WDOG);
  assign irq_rise  = vcount[IRQ_VBIT] && !vbit_q;

  always_comb begin
    rd_data_d = '0;
    if (cpu_read) begin
      case (region)
        ADR_DSW: rd_data_d = cpu_addr[0] ? sw_dsw2 : sw_dsw1;
        ADR_IN: begin
          case (cpu_addr[1:0])
            2'd0:    rd_data_d = sw_in0;
            2'd1:    rd_data_d = sw_in1;
            2'd2:    rd_data_d = sw_in2;
            default: rd_data_d = sw_in3;
          endcase
        end
        default: rd_data_d = '0;
      endcase
    end
  end

  always_comb begin
    out_latch_d = out_latch_q;
    if (wr_stb && (region == ADR_OUTLAT)) begin
      out_latch_d[cpu_addr[2:0]] = cpu_wr_data[7];
    end
  end

  // A fresh 32V edge wins over a same-edge acknowledge
  always_comb begin
    irq_d = irq_q;
    if (irq_rise) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      rd_data_q   <= '0;
      out_latch_q <= '0;
      irq_q       <= 1'b0;
      vbit_q      <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      out_latch_q <= out_latch_d;
      irq_q       <= irq_d;
      vbit_q      <= vcount[IRQ_VBIT];
    end
  end

  assign ext_rd_data = rd_data_q;
  assign out_latch   = out_latch_q;
  assign cpu_irq     = irq_q;

`ifdef CENTIPEDE_WATCHDOG_EN
  logic              vblank_q;
  logic [WDOG_W-1:0] wdog_count;

  always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
    end
  end

  centipede_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .WDOG_W     (WDOG_W)
  ) u_watchdog (
    .clk         (clk_cpu_4x),
    .rst_n       (reset_cpu_n),
    .kick        (wdog_kick),
    .vblank_rise (vblank && !vblank_q),
    .count       (wdog_count),
    .wdog_reset  (wdog_reset)
  );

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[15:14], cpu_addr[9:3], cpu_wr_data[6:0], vcount, wdog_count};
`else
  localparam int unused_wdog_cfg = WDOG_LIMIT + WDOG_W;

  assign wdog_reset = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[15:14], cpu_addr[9:3], cpu_wr_data[6:0], vcount, vblank, wdog_kick};
`endif

endmodule

// File: tb/tb_centipede_io_responder.sv
// tb/tb_centipede_io_responder.sv - Scoreboarded bench for centipede_io_responder
module tb_centipede_io_responder;
  import centipede_io_pkg::*;

`ifdef CENTIPEDE_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  logic        clk_cpu_4x = 1'b0;
  logic        reset_cpu_n;
  logic        clk_cpu, clk_cpu_2x;
  logic        cpu_read;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  ext_rd_data;
  logic [7:0]  sw_dsw1, sw_dsw2, sw_in0, sw_in1, sw_in2, sw_in3;
  logic [7:0]  vcount;
  logic        vblank;
  logic        cpu_irq;
  logic [7:0]  out_latch;
  logic        wdog_reset;

  int          ph;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];

  centipede_io_responder dut (
    .clk_cpu_4x  (clk_cpu_4x),
    .reset_cpu_n (reset_cpu_n),
    .clk_cpu     (clk_cpu),
    .clk_cpu_2x  (clk_cpu_2x),
    .cpu_read    (cpu_read),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .ext_rd_data (ext_rd_data),
    .sw_dsw1     (sw_dsw1),
    .sw_dsw2     (sw_dsw2),
    .sw_in0      (sw_in0),
    .sw_in1      (sw_in1),
    .sw_in2      (sw_in2),
    .sw_in3      (sw_in3),
    .vcount      (vcount),
    .vblank      (vblank),
    .cpu_irq     (cpu_irq),
    .out_latch   (out_latch),
    .wdog_reset  (wdog_reset)
  );

  initial forever #5 clk_cpu_4x = ~clk_cpu_4x;

  // ph is the phase the next rising edge will see; ph==2 is the write-strobe edge
  initial begin
    ph = 0;
    clk_cpu = 1'b1;
    clk_cpu_2x = 1'b1;
    forever begin
      @(posedge clk_cpu_4x);
      #1;
      ph = (ph + 1) % 4;
      clk_cpu = (ph == 0);
      clk_cpu_2x = (ph % 2 == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_cpu_4x);
    cpu_read = 1'b0;
    cpu_addr = a;
    cpu_wr_data = d;
    repeat (4) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    cpu_read = 1'b1;
    cpu_addr = 16'h0400;
  endtask

  task automatic cpu_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk_cpu_4x);
    cpu_read = 1'b1;
    cpu_addr = a;
    exp_q.push_back(exp);
    @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, ext_rd_data}, {24'd0, e});
    end
  endtask

  task automatic wait_ph(input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk_cpu_4x);
      if (ph == p) found = 1'b1;
    end
    if (!found) check("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic vb_rise();
    @(negedge clk_cpu_4x);
    vblank = 1'b1;
    repeat (2) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    vblank = 1'b0;
    repeat (2) @(posedge clk_cpu_4x);
  endtask

  task automatic pulse_reset();
    @(negedge clk_cpu_4x);
    vcount = 8'h00;
    reset_cpu_n = 1'b0;
    #2;
    @(negedge clk_cpu_4x);
    reset_cpu_n = 1'b1;
  endtask

  initial begin
    reset_cpu_n = 1'b0;
    cpu_read = 1'b1;
    cpu_addr = 16'h0400;
    cpu_wr_data = 8'h00;
    sw_dsw1 = 8'h3C; sw_dsw2 = 8'hC3;
    sw_in0 = 8'h11; sw_in1 = 8'h22; sw_in2 = 8'hA5; sw_in3 = 8'h44;
    vcount = 8'h00;
    vblank = 1'b0;
    #3;
    check("rst_rd", {24'd0, ext_rd_data}, 32'h0);
    check("rst_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_latch", {24'd0, out_latch}, 32'h0);
    check("rst_wdog", {31'd0, wdog_reset}, 32'd0);
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    reset_cpu_n = 1'b1;

    // Read decode sweep
    cpu_rd("rd_in2", 16'h0C02, 8'hA5);
    cpu_rd("rd_in2_mirror", 16'hCC02, 8'hA5);
    cpu_rd("rd_unmapped", 16'h0400, 8'h00);
    cpu_rd("rd_dsw1", 16'h0800, 8'h3C);
    cpu_rd("rd_dsw2", 16'h0801, 8'hC3);
    cpu_rd("rd_in0", 16'h0C00, 8'h11);
    cpu_rd("rd_in1", 16'h0C01, 8'h22);
    cpu_rd("rd_in3", 16'h0C03, 8'h44);
    cpu_rd("rd_outlat_space", 16'h1C00, 8'h00);

    // Output latch
    cpu_wr(16'h1C03, 8'h80);
    check("latch_set3", {24'd0, out_latch}, 32'h08);
    check("latch_led1", {31'd0, out_latch[LED1]}, 32'd1);
    cpu_wr(16'h1C07, 8'h80);
    check("latch_set7", {24'd0, out_latch}, 32'h88);
    check("latch_flip", {31'd0, out_latch[FLIP]}, 32'd1);
    cpu_wr(16'h1C03, 8'h7F);
    check("latch_clr3", {24'd0, out_latch}, 32'h80);
    check("latch_coins", {29'd0, out_latch[COIN_R], out_latch[COIN_C], out_latch[COIN_L]}, 32'd0);
    check("latch_led2", {31'd0, out_latch[LED2]}, 32'd0);

    // Write to an input port address: read bus stays 0, nothing changes
    @(negedge clk_cpu_4x);
    cpu_read = 1'b0;
    cpu_addr = 16'h0C00;
    cpu_wr_data = 8'hFF;
    repeat (4) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("wr_in0_rd", {24'd0, ext_rd_data}, 32'h0);
    check("wr_in0_latch", {24'd0, out_latch}, 32'h80);
    check("wr_in0_irq", {31'd0, cpu_irq}, 32'd0);
    cpu_read = 1'b1;
    cpu_addr = 16'h0400;

    // IRQ set, hold, acknowledge, then set-beats-ack
    vcount = 8'h1F;
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("irq_pre", {31'd0, cpu_irq}, 32'd0);
    vcount = 8'h20;
    repeat (2) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("irq_set", {31'd0, cpu_irq}, 32'd1);
    repeat (20) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("irq_hold", {31'd0, cpu_irq}, 32'd1);
    cpu_wr(16'h1800, 8'h55);
    check("irq_ack", {31'd0, cpu_irq}, 32'd0);
    vcount = 8'h1F;
    repeat (4) @(posedge clk_cpu_4x);
    wait_ph(2);
    cpu_read = 1'b0;
    cpu_addr = 16'h1800;
    vcount = 8'h20;
    @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    cpu_read = 1'b1;
    cpu_addr = 16'h0400;
    repeat (2) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("irq_set_beats_ack", {31'd0, cpu_irq}, 32'd1);
    cpu_wr(16'h1800, 8'h00);
    check("irq_ack2", {31'd0, cpu_irq}, 32'd0);

    // Watchdog: 8 rises without a kick
    pulse_reset();
    repeat (7) vb_rise();
    check("wdog_7", {31'd0, wdog_reset}, 32'd0);
    vb_rise();
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("wdog_8", {31'd0, wdog_reset}, {31'd0, WD});
    cpu_wr(16'h2000, 8'h00);
    check("wdog_sticky", {31'd0, wdog_reset}, {31'd0, WD});

    // Kick after 7 restarts the count
    pulse_reset();
    repeat (7) vb_rise();
    cpu_wr(16'h2000, 8'h00);
    repeat (7) vb_rise();
    check("wdog_kick7", {31'd0, wdog_reset}, 32'd0);
    vb_rise();
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("wdog_kick7_then8", {31'd0, wdog_reset}, {31'd0, WD});

    // Kick coincident with the 8th rise
    pulse_reset();
    repeat (7) vb_rise();
    wait_ph(2);
    vblank = 1'b1;
    cpu_read = 1'b0;
    cpu_addr = 16'h2000;
    @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    cpu_read = 1'b1;
    cpu_addr = 16'h0400;
    repeat (2) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    vblank = 1'b0;
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("wdog_kick_coincident", {31'd0, wdog_reset}, 32'd0);
    repeat (7) vb_rise();
    check("wdog_coinc_7more", {31'd0, wdog_reset}, 32'd0);

    // Async reset mid-operation
    pulse_reset();
    for (int i = 0; i < 8; i++) cpu_wr(16'h1C00 + 16'(i), 8'h80);
    repeat (5) vb_rise();
    vcount = 8'h20;
    cpu_addr = 16'h0800;
    repeat (2) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("pre_rst_latch", {24'd0, out_latch}, 32'hFF);
    check("pre_rst_irq", {31'd0, cpu_irq}, 32'd1);
    check("pre_rst_rd", {24'd0, ext_rd_data}, 32'h3C);
    #1;
    reset_cpu_n = 1'b0;
    vcount = 8'h00;
    #1;
    check("async_rst_latch", {24'd0, out_latch}, 32'h0);
    check("async_rst_irq", {31'd0, cpu_irq}, 32'd0);
    check("async_rst_rd", {24'd0, ext_rd_data}, 32'h0);
    @(negedge clk_cpu_4x);
    reset_cpu_n = 1'b1;
    cpu_rd("post_rst_dsw2", 16'h0801, 8'hC3);
    cpu_rd("post_rst_in2", 16'h0C02, 8'hA5);
    repeat (3) vb_rise();
    check("post_rst_count", {31'd0, wdog_reset}, 32'd0);
    repeat (5) vb_rise();
    repeat (3) @(posedge clk_cpu_4x);
    @(negedge clk_cpu_4x);
    check("post_rst_wdog8", {31'd0, wdog_reset}, {31'd0, WD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
